// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcode, NOP and stall-mask definitions for the decode stage.
package id_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [XLEN-1:0] ZeroWord = '0;

    localparam logic [6:0] NOP_TYPE    = OPC_OP_IMM;
    localparam logic [2:0] NOP_DETAILS = 3'b000;
    localparam logic       NOP_DIFF    = 1'b0;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
    localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OPC_OP:                          return FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:  return FMT_I;
            OPC_STORE:                       return FMT_S;
            OPC_BRANCH:                      return FMT_B;
            OPC_LUI, OPC_AUIPC:              return FMT_U;
            OPC_JAL:                         return FMT_J;
            default:                         return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// id_stage_regfile: 32x32 register file, x0 hardwired to zero, reads bypass the in-flight writeback.
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    input  logic            we_in,
    input  logic [4:0]      waddr_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [4:0]      raddr1_in,
    input  logic [4:0]      raddr2_in,
    output logic [XLEN-1:0] rdata1_out,
    output logic [XLEN-1:0] rdata2_out
);

    logic [XLEN-1:0] regs_q [REG_NUM];
    logic [XLEN-1:0] regs_d [REG_NUM];

    always_comb begin
        regs_d = regs_q;
        if (rdy_in && we_in && waddr_in != 5'd0) regs_d[waddr_in] = wdata_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) regs_q <= '{default: '0};
        else           regs_q <= regs_d;
    end

    // Bypass ignores rdy_in: the value on the WB bus is what this cycle should see.
    assign rdata1_out = raddr1_in == 5'd0 ? ZeroWord :
                        (we_in && waddr_in == raddr1_in) ? wdata_in : regs_q[raddr1_in];
    assign rdata2_out = raddr2_in == 5'd0 ? ZeroWord :
                        (we_in && waddr_in == raddr2_in) ? wdata_in : regs_q[raddr2_in];

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, register read with WB bypass, load-use hazard bubble insertion.
module id_stage
    import id_stage_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic            wb_enable,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      r1_addr,
    output logic [4:0]      r2_addr,
    output logic [XLEN-1:0] r1_data,
    output logic [XLEN-1:0] r2_data,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      ins_type,
    output logic [2:0]      ins_details,
    output logic            ins_diff,
    output logic            stall_req_id,
    output logic            illegal_seen
);

    fmt_e            fmt;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      r1_dec, r2_dec, rd_dec;
    logic [XLEN-1:0] imm_dec, r1_rf, r2_rf;
    logic            diff_dec, illegal, hazard, bubble;
    logic            illegal_seen_q, illegal_seen_d;

    always_comb begin
        opcode   = if_inst[6:0];
        funct3   = if_inst[14:12];
        fmt      = fmt_of(opcode);
        illegal  = fmt == FMT_X;
        r1_dec   = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B} ? if_inst[19:15] : 5'd0;
        r2_dec   = fmt inside {FMT_R, FMT_S, FMT_B} ? if_inst[24:20] : 5'd0;
        rd_dec   = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J} ? if_inst[11:7] : 5'd0;
        imm_dec  = fmt == FMT_I ? {{20{if_inst[31]}}, if_inst[31:20]} :
                   fmt == FMT_S ? {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]} :
                   fmt == FMT_B ? {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0} :
                   fmt == FMT_U ? {if_inst[31:12], 12'b0} :
                   fmt == FMT_J ? {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0} :
                   ZeroWord;
        diff_dec = (opcode == OPC_OP || (opcode == OPC_OP_IMM && funct3 == 3'b101)) && if_inst[30];
        // Illegal opcodes decode with zero sources, so they can never raise a hazard.
        hazard   = ex_is_load && ex_rd_addr != 5'd0 && (ex_rd_addr == r1_dec || ex_rd_addr == r2_dec);
        bubble   = illegal || hazard || !rst_n_in;
        illegal_seen_d = illegal_seen_q || (rdy_in && illegal);
    end

    id_stage_regfile u_regfile (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rdy_in    (rdy_in),
        .we_in     (wb_enable),
        .waddr_in  (wb_addr),
        .wdata_in  (wb_data),
        .raddr1_in (r1_dec),
        .raddr2_in (r2_dec),
        .rdata1_out(r1_rf),
        .rdata2_out(r2_rf)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) illegal_seen_q <= 1'b0;
        else           illegal_seen_q <= illegal_seen_d;
    end

    always_comb begin
        pc           = if_pc;
        r1_addr      = bubble ? 5'd0 : r1_dec;
        r2_addr      = bubble ? 5'd0 : r2_dec;
        r1_data      = bubble ? ZeroWord : r1_rf;
        r2_data      = bubble ? ZeroWord : r2_rf;
        rd_addr      = bubble ? 5'd0 : rd_dec;
        imm          = bubble ? ZeroWord : imm_dec;
        ins_type     = bubble ? NOP_TYPE : opcode;
        ins_details  = bubble ? NOP_DETAILS : funct3;
        ins_diff     = bubble ? NOP_DIFF : diff_dec;
        stall_req_id = hazard && rst_n_in;
        illegal_seen = illegal_seen_q;
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against a behavioural RV32I decode model.
module tb_id_stage;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] if_pc = '0, if_inst = 32'h13;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_is_load = 1'b0;
    logic [4:0]  ex_rd_addr = '0;
    logic [31:0] pc, r1_data, r2_data, imm;
    logic [4:0]  r1_addr, r2_addr, rd_addr;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic        ins_diff, stall_req_id, illegal_seen;

    always #5 clk_in = ~clk_in;

    id_stage dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .if_pc(if_pc), .if_inst(if_inst),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
        .pc(pc), .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_data(r1_data), .r2_data(r2_data),
        .rd_addr(rd_addr), .imm(imm), .ins_type(ins_type), .ins_details(ins_details),
        .ins_diff(ins_diff), .stall_req_id(stall_req_id), .illegal_seen(illegal_seen)
    );

    typedef struct {
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  r1a, r2a, rda;
        logic [6:0]  typ;
        logic [2:0]  det;
        logic        diff, stall, ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    logic        mill;
    int          n_cmp = 0, n_err = 0;

    task automatic ck(input string n, input logic [31:0] g, input logic [31:0] w);
        n_cmp++;
        if (g !== w) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, g, w);
        end
    endtask

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_enable && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    // Expected outputs for the current inputs, derived from the ISA field layout.
    function automatic exp_t ref_model();
        exp_t e = '{default: '0};
        logic [31:0] i = if_inst;
        logic signed [31:0] si = if_inst;
        logic [31:0] s20, s19, s11, v;
        logic [4:0] s1, s2, d;
        logic [6:0] op = i[6:0];
        s20 = si >>> 20;
        s19 = si >>> 19;
        s11 = si >>> 11;
        e.pc = if_pc;
        e.typ = 7'h13;
        e.ill = rst_n_in ? mill : 1'b0;
        if (!rst_n_in || !legal_op(op)) return e;
        s1 = i[19:15]; s2 = i[24:20]; d = i[11:7]; v = 0;
        if (op inside {7'h03, 7'h13, 7'h67}) begin s2 = 0; v = s20; end
        if (op == 7'h23) begin d = 0; v = (s20 & ~32'h1f) | 32'(i[11:7]); end
        if (op == 7'h63) begin
            d = 0;
            v = (s19 & 32'hFFFF_F000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        end
        if (op inside {7'h37, 7'h17}) begin s1 = 0; s2 = 0; v = i & 32'hFFFF_F000; end
        if (op == 7'h6f) begin
            s1 = 0; s2 = 0;
            v = (s11 & 32'hFFF0_0000) | (i & 32'h000F_F000) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        end
        if (ex_is_load && ex_rd_addr != 0 && (ex_rd_addr == s1 || ex_rd_addr == s2)) begin
            e.stall = 1;
            return e;
        end
        e.r1a = s1; e.r2a = s2; e.rda = d; e.imm = v;
        e.r1d = rd_reg(s1); e.r2d = rd_reg(s2);
        e.typ = op; e.det = i[14:12];
        e.diff = i[30] && (op == 7'h33 || (op == 7'h13 && i[14:12] == 3'b101));
        return e;
    endfunction

    task automatic step(input logic [31:0] inst, input logic wbe, input logic [4:0] wba,
                        input logic [31:0] wbd, input logic exl, input logic [4:0] exr, input logic rdy);
        @(posedge clk_in);
        #1;
        rst_n_in = 1; rdy_in = rdy; if_inst = inst; if_pc = $urandom;
        wb_enable = wbe; wb_addr = wba; wb_data = wbd; ex_is_load = exl; ex_rd_addr = exr;
        q.push_back(ref_model());
        if (rdy && wbe && wba != 0) mregs[wba] = wbd;
        if (rdy && !legal_op(inst[6:0])) mill = 1;
    endtask

    task automatic rst_cycle();
        @(posedge clk_in);
        #1;
        rst_n_in = 0; if_inst = $urandom; if_pc = $urandom;
        ex_is_load = 1; ex_rd_addr = if_inst[19:15];
        q.push_back(ref_model());
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        mill = 0;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            ck("pc", pc, e.pc);
            ck("addrs", 32'({r1_addr, r2_addr, rd_addr}), 32'({e.r1a, e.r2a, e.rda}));
            ck("r1_data", r1_data, e.r1d);
            ck("r2_data", r2_data, e.r2d);
            ck("imm", imm, e.imm);
            ck("type_det_diff", 32'({ins_type, ins_details, ins_diff}), 32'({e.typ, e.det, e.diff}));
            ck("stall", 32'(stall_req_id), 32'(e.stall));
            ck("illegal_seen", 32'(illegal_seen), 32'(e.ill));
        end
    end

    logic [6:0] ops [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    initial begin
        logic [31:0] ri;
        rst_cycle();
        step(32'h0050_0093, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_addi_type", 32'(ins_type), 32'h13);
        ck("d_addi_rd", 32'(rd_addr), 1);
        ck("d_addi_imm", imm, 5);
        ck("d_addi_r1", r1_data, 0);
        step(32'h0020_81B3, 1, 2, 32'hDEAD_BEEF, 0, 0, 1);
        @(negedge clk_in);
        ck("d_bypass", r2_data, 32'hDEAD_BEEF);
        step(32'h0020_81B3, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_stored", r2_data, 32'hDEAD_BEEF);
        step(32'h0020_81B3, 0, 0, 0, 1, 1, 1);
        @(negedge clk_in);
        ck("d_hazard_stall", 32'(stall_req_id), 1);
        ck("d_hazard_nop", 32'({ins_type, rd_addr}), 32'({7'h13, 5'd0}));
        step(32'h0020_81B3, 0, 0, 0, 0, 1, 1);
        @(negedge clk_in);
        ck("d_release", 32'({stall_req_id, ins_type, rd_addr}), 32'({1'b0, 7'h33, 5'd3}));
        step(32'hFE00_0EE3, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_beq_imm", imm, 32'hFFFF_FFFC);
        step(32'h4030_D093, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_srai", 32'({ins_diff, imm[11:0]}), 32'h1403);
        step(32'h0000_0093, 1, 0, 32'h1234, 0, 0, 1);
        @(negedge clk_in);
        ck("d_x0", r1_data, 0);
        step(32'h0002_8093, 1, 5, 32'h55, 0, 0, 0);
        step(32'h0002_8093, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_rdy_low", r1_data, 0);
        step(32'hFFFF_FFFF, 0, 0, 0, 1, 31, 1);
        @(negedge clk_in);
        ck("d_illegal_nop", 32'({ins_type, stall_req_id, illegal_seen}), 32'({7'h13, 2'b00}));
        step(32'h0050_0093, 0, 0, 0, 0, 0, 1);
        step(32'h0050_0093, 0, 0, 0, 0, 0, 1);
        @(negedge clk_in);
        ck("d_illegal_sticky", 32'(illegal_seen), 1);
        rst_cycle();
        @(negedge clk_in);
        ck("d_illegal_clear", 32'(illegal_seen), 0);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) rst_cycle();
            ri = $urandom;
            ri[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) begin
                ri[19:15] = 5'($urandom_range(0, 7));
                ri[24:20] = 5'($urandom_range(0, 7));
                ri[11:7]  = 5'($urandom_range(0, 7));
            end
            step(ri, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 7) != 0);
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk_in);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage sitting between the IF/ID register and the ID/EX pipeline register. It decodes the RV32I word into the fields ID/EX latches:
- pc, r1/r2 address and data, rd, imm, ins_type, ins_details, ins_diff.

It owns the 32×32 architectural register file, with a write-through read bypass from writeback. It also detects load-use hazards, and inserts a bubble by forcing a NOP and raising a stall request.

## Interface
- XLEN, 32, data/pc width
- REG_NUM, 32, architectural registers (address width 5)

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- if_pc  input  32  pc from IF/ID
- if_inst  input  32  instruction word from IF/ID
- wb_enable  input  1  writeback valid
- wb_addr  input  5  writeback destination
- wb_data  input  32  writeback value
- ex_is_load  input  1  instruction currently in EX is a LOAD
- ex_rd_addr  input  5  rd of instruction currently in EX
- pc  output  32  passthrough of if_pc
- r1_addr, r2_addr  output  5 each  source addresses (0 when unused)
- r1_data, r2_data  output  32 each  source values
- rd_addr  output  5  destination (0 when none)
- imm  output  32  sign-extended immediate
- ins_type  output  7  opcode
- ins_details  output  3  funct3
- ins_diff  output  1  inst[30] qualifier
- stall_req_id  output  1  load-use stall request to stall controller
- illegal_seen  output  1  sticky: an unsupported opcode was decoded

## Operation
- Register file:
  - x0 reads 0 and is never written.
  - Write at posedge when rdy_in && wb_enable && wb_addr≠0.
- Read bypass: if wb_enable && wb_addr≠0 && wb_addr==rN_addr, rN_data=wb_data; otherwise the stored value.
- Format decode by inst[6:0]:
  - R (OP 0110011): rs1, rs2, rd; imm 0.
  - I (LOAD 0000011, OP-IMM 0010011, JALR 1100111): rs1, rd; imm=sext(inst[31:20]).
  - S (STORE 0100011): rs1, rs2; imm=sext({inst[31:25],inst[11:7]}); rd 0.
  - B (BRANCH 1100011): rs1, rs2; imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); rd 0.
  - U (LUI 0110111, AUIPC 0010111): rd; imm={inst[31:12],12'b0}.
  - J (JAL 1101111): rd; imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- Unused source/destination fields output 0.
- ins_details=inst[14:12] for all formats.
- ins_diff=inst[30] only for OP, and for OP-IMM with funct3=101; else 0.
- NOP is ADDI x0,x0,0:
  - ins_type 0010011; all addresses, data, imm, details and diff 0.
  - pc still passes through.
- Illegal opcode (any other opcode): outputs NOP; illegal_seen set at next posedge when rdy_in.
- Load-use hazard: ex_is_load && ex_rd_addr≠0 && (ex_rd_addr==r1_addr or ex_rd_addr==r2_addr).
  - The comparison uses the decoded, zeroed addresses.
  - On hazard: stall_req_id=1 and outputs forced to NOP, so ID/EX latches a bubble while IF/ID holds.
- rst_n_in low (asynchronous):
  - All registers, including the register file, reset to 0; illegal_seen=0.
  - While reset is asserted: outputs NOP, stall_req_id=0.

## Timing
- Decode, register read, bypass and hazard detection are combinational: zero-cycle latency from if_inst / wb_* / ex_* to the outputs.
- Writeback is stored at the posedge and is visible the same cycle through the bypass, so WB→ID needs no extra forwarding.
- Load-use: stall_req_id is high for exactly the cycle(s) in which the condition holds. Once the bubble reaches EX, ex_is_load drops and the stall releases with no internal counter.
- rdy_in low: no register-file write and illegal_seen holds; the combinational outputs still follow their inputs.
- Simultaneous wb write to rd=rs1=rs2: both data ports show wb_data.
- Hazard together with an illegal opcode: the NOP is output and stall_req_id=0, because NOP has no sources.
- Reset deasserted mid-stream: the first post-reset decode reads all-zero registers.

## Structure
- Shared defines file holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ADDI/OP-IMM, OP);
  - ZeroWord;
  - the NOP field values;
  - STALL_* masks.
- One sub-module: regfile (32×32, async active-low reset, one write port, two read ports with write-through bypass). Decode and hazard logic live in id_stage.

## Test plan
- Reset, then if_inst=0x00500093 (addi x1,x0,5) → ins_type 0010011, rd_addr 1, r1_addr 0, imm 5, r1_data 0, stall_req_id 0.
- WB writes x2=0xDEADBEEF while if_inst=0x002081B3 (add x3,x1,x2) → r2_data 0xDEADBEEF in the same cycle. Next cycle with wb_enable=0 → still 0xDEADBEEF.
- ex_is_load=1, ex_rd_addr=1, if_inst=add x3,x1,x2 → stall_req_id 1, outputs NOP. ex_is_load=0 next cycle → stall released and original decode restored.
- if_inst=0xFE000EE3 (beq x0,x0,-4) → imm 0xFFFFFFFC, rd_addr 0. if_inst=0x4030D093 (srai x1,x1,3) → ins_diff 1, imm 0x403.
- if_inst=0xFFFFFFFF → NOP outputs; illegal_seen rises next edge and stays set; clears only on rst_n_in low.
- Writeback to x0 with 0x1234 → r1_data for r1_addr 0 stays 0. rdy_in=0 during a wb write to x5 → x5 unchanged after rdy_in returns.
